rope_field: RTL and testbench

ROPE_FIELD -- requirements
Module: rope_field

---
 rtl/tow_pkg.sv | 21 ++
 rtl/score_counter.sv | 22 ++
 rtl/rope_field.sv | 129 ++++++++++++
 tb/tb_rope_field.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war game: field states, round
// winner encodings and default sizing used by the field, player and computer stages.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    HOLD = 2'b01,
    OVER = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_t;

  localparam int DEF_NUM_LEDS    = 9;
  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_HOLD_CYCLES = 4;

endpackage

// File: rtl/score_counter.sv
// 3-bit round-win counter with synchronous reset and an increment enable;
// saturates at LIMIT so a score can never wrap.
module score_counter #(
  parameter int LIMIT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [2:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != 3'(LIMIT))) begin
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/rope_field.sv
// Tug-of-war playfield: a marker index pushed by two players, round wins at
// either end, a fixed result hold, and a match end once a score reaches WIN_SCORE.
module rope_field
  import tow_pkg::*;
#(
  parameter int NUM_LEDS    = DEF_NUM_LEDS,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                left_press,
  input  logic                right_press,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          winner,
  output logic [2:0]          score_l,
  output logic [2:0]          score_r,
  output logic                game_over
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [POS_W-1:0] POS_CENTRE = POS_W'((NUM_LEDS - 1) / 2);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  state_t              state, state_d;
  logic [POS_W-1:0]    pos, pos_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  winner_t             winner_q, winner_d;
  logic [NUM_LEDS-1:0] leds_d;
  logic                over_d;
  logic                inc_l, inc_r;
  logic                lone_left, lone_right, match_won;

  assign lone_left  = left_press && !right_press;
  assign lone_right = right_press && !left_press;
  assign match_won  = (score_l == 3'(WIN_SCORE)) || (score_r == 3'(WIN_SCORE));
  assign winner     = winner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      pos       <= POS_CENTRE;
      cnt       <= '0;
      winner_q  <= WIN_NONE;
      leds      <= LED_ONE << POS_CENTRE;
      game_over <= 1'b0;
    end else begin
      state     <= state_d;
      pos       <= pos_d;
      cnt       <= cnt_d;
      winner_q  <= winner_d;
      leds      <= leds_d;
      game_over <= over_d;
    end
  end

  // NOTE: every combinational output is defaulted before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d  = state;
    pos_d    = pos;
    cnt_d    = cnt;
    winner_d = winner_q;
    over_d   = game_over;
    inc_l    = 1'b0;
    inc_r    = 1'b0;

    unique case (state)
      PLAY: begin
        cnt_d = '0;
        if (lone_left) begin
          if (pos == POS_LAST) begin
            state_d  = HOLD;
            winner_d = WIN_LEFT;
            inc_l    = 1'b1;
          end else begin
            pos_d = pos + POS_W'(1);
          end
        end else if (lone_right) begin
          if (pos == '0) begin
            state_d  = HOLD;
            winner_d = WIN_RIGHT;
            inc_r    = 1'b1;
          end else begin
            pos_d = pos - POS_W'(1);
          end
        end
      end
      HOLD: begin
        // Scores were already updated on entry, so the match check is current here.
        if (cnt == HOLD_LAST) begin
          cnt_d = '0;
          if (match_won) begin
            state_d = OVER;
            over_d  = 1'b1;
          end else begin
            state_d  = PLAY;
            pos_d    = POS_CENTRE;
            winner_d = WIN_NONE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      OVER: ;
      default: state_d = PLAY;
    endcase

    leds_d = (state_d == PLAY) ? (LED_ONE << pos_d) : '0;
  end

  score_counter #(.LIMIT(WIN_SCORE)) u_score_l (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_l),
    .count (score_l)
  );

  score_counter #(.LIMIT(WIN_SCORE)) u_score_r (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_r),
    .count (score_r)
  );

endmodule

// File: tb/tb_rope_field.sv
// Bench for rope_field: an integer game model checked every cycle, plus
// directed literal expectations for reset, round wins, cancels, hold and match end.
module tb_rope_field;

  localparam int N    = 9;
  localparam int WS   = 7;
  localparam int HOLD = 4;
  localparam int CTR  = (N - 1) / 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         left_press = 1'b0;
  logic         right_press = 1'b0;
  logic [N-1:0] leds;
  logic [1:0]   winner;
  logic [2:0]   score_l, score_r;
  logic         game_over;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: mode 0 = playing, 1 = showing result, 2 = match over.
  int m_mode = 0, m_pos = CTR, m_win = 0, m_sl = 0, m_sr = 0, m_hold = 0;

  rope_field #(.NUM_LEDS(N), .WIN_SCORE(WS), .HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .left_press  (left_press),
    .right_press (right_press),
    .leds        (leds),
    .winner      (winner),
    .score_l     (score_l),
    .score_r     (score_r),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_pos = CTR; m_win = 0; m_sl = 0; m_sr = 0; m_hold = 0;
    end else if (m_mode == 0) begin
      if (left_press && !right_press) begin
        if (m_pos == N - 1) begin
          m_win = 1; m_sl = (m_sl < WS) ? m_sl + 1 : WS; m_mode = 1; m_hold = HOLD;
        end else m_pos = m_pos + 1;
      end else if (right_press && !left_press) begin
        if (m_pos == 0) begin
          m_win = 2; m_sr = (m_sr < WS) ? m_sr + 1 : WS; m_mode = 1; m_hold = HOLD;
        end else m_pos = m_pos - 1;
      end
    end else if (m_mode == 1) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) begin
        if (m_sl == WS || m_sr == WS) m_mode = 2;
        else begin m_mode = 0; m_pos = CTR; m_win = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] exp_leds;
      exp_leds = (m_mode == 0) ? (N'(1) << m_pos) : '0;
      check("model_leds", 32'(leds), 32'(exp_leds));
      check("model_winner", 32'(winner), 32'(m_win));
      check("model_score_l", 32'(score_l), 32'(m_sl));
      check("model_score_r", 32'(score_r), 32'(m_sr));
      check("model_game_over", 32'(game_over), 32'(m_mode == 2));
    end
  end

  task automatic step(input logic l, input logic r);
    left_press  = l;
    right_press = r;
    @(posedge clk);
    #1;
    left_press  = 1'b0;
    right_press = 1'b0;
  endtask

  task automatic steps(input int n, input logic l, input logic r);
    for (int i = 0; i < n; i++) step(l, r);
  endtask

  initial begin
    reset = 1'b1;
    steps(5, 1'b0, 1'b0);
    cmp_en = 1'b1;
    reset  = 1'b0;
    check("reset_leds", 32'(leds), 32'(9'b000010000));
    check("reset_winner", 32'(winner), 32'd0);
    check("reset_scores", {score_l, score_r}, 32'd0);
    check("reset_game_over", 32'(game_over), 32'd0);

    // Left win from centre, held press moves once per cycle.
    steps(4, 1'b1, 1'b0);
    check("left_at_end", 32'(leds), 32'(9'b100000000));
    step(1'b1, 1'b0);
    check("left_win_leds", 32'(leds), 32'd0);
    check("left_win_winner", 32'(winner), 32'b01);
    check("left_win_score", 32'(score_l), 32'd1);
    steps(HOLD - 1, 1'b0, 1'b0);
    check("hold_last_cycle", 32'(leds), 32'd0);
    step(1'b0, 1'b0);
    check("restart_leds", 32'(leds), 32'(9'b000010000));
    check("restart_winner", 32'(winner), 32'd0);

    // Simultaneous presses cancel.
    steps(3, 1'b1, 1'b1);
    check("cancel_leds", 32'(leds), 32'(9'b000010000));

    // Right win, then presses during HOLD ignored.
    steps(5, 1'b0, 1'b1);
    check("right_win_winner", 32'(winner), 32'b10);
    check("right_win_score", 32'(score_r), 32'd1);
    steps(HOLD, 1'b0, 1'b1);
    check("hold_ignore_leds", 32'(leds), 32'(9'b000010000));
    check("hold_ignore_score_r", 32'(score_r), 32'd1);
    step(1'b1, 1'b0);
    check("after_hold_move", 32'(leds), 32'(9'b000100000));
    step(1'b0, 1'b1);

    // Six more right wins end the match.
    for (int w = 0; w < WS - 1; w++) begin
      steps(5, 1'b0, 1'b1);
      steps(HOLD, 1'b0, 1'b0);
    end
    check("over_score_r", 32'(score_r), 32'd7);
    check("over_game_over", 32'(game_over), 32'd1);
    check("over_winner", 32'(winner), 32'b10);
    steps(3, 1'b1, 1'b0);
    steps(3, 1'b0, 1'b1);
    check("over_ignore", {29'd0, game_over, score_r[1:0]}, 32'b111);
    check("over_leds", 32'(leds), 32'd0);
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    check("over_reset_leds", 32'(leds), 32'(9'b000010000));
    check("over_reset_state", {winner, score_l, score_r, game_over}, 32'd0);

    // Reset on the second HOLD cycle.
    steps(5, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("mid_hold_leds", 32'(leds), 32'd0);
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    check("mid_hold_reset_leds", 32'(leds), 32'(9'b000010000));
    check("mid_hold_reset_score", 32'(score_l), 32'd0);
    check("mid_hold_reset_winner", 32'(winner), 32'd0);
    steps(2, 1'b0, 1'b1);
    check("post_reset_move", 32'(leds), 32'(9'b000000100));

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
